// File: rtl/dlfloat_pkg.sv
// Shared DLFloat constants and sequencer state encoding.
package dlfloat_pkg;

  localparam int              DLF_W    = 16;
  localparam logic [DLF_W-1:0] DLF_NAN  = 16'hFFFF;
  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
  localparam int              DLF_BIAS = 31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // DLFloat uses a single all-ones pattern as its NaN.
  function automatic logic is_nan(input logic [DLF_W-1:0] v);
    return v == DLF_NAN;
  endfunction

endpackage

// File: rtl/dlfloat_mac_seq_if.sv
// Job, operand, MAC and result signals of the dot-product sequencer.
interface dlfloat_mac_seq_if
  import dlfloat_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic             start;
  logic [CNT_W-1:0] vec_len;
  logic             op_valid;
  logic             op_ready;
  logic [DLF_W-1:0] op_a;
  logic [DLF_W-1:0] op_b;
  logic [DLF_W-1:0] mac_a;
  logic [DLF_W-1:0] mac_b;
  logic             mac_clr;
  logic [DLF_W-1:0] mac_c;
  logic             res_valid;
  logic             res_ready;
  logic [DLF_W-1:0] res_data;
  logic             res_err;
  logic             busy;

  // Environment side: issues jobs, supplies operands, hosts the MAC, takes results.
  modport master (
    output start, vec_len, op_valid, op_a, op_b, mac_c, res_ready,
    input  op_ready, mac_a, mac_b, mac_clr, res_valid, res_data, res_err, busy
  );

  // Sequencer side.
  modport slave (
    input  start, vec_len, op_valid, op_a, op_b, mac_c, res_ready,
    output op_ready, mac_a, mac_b, mac_clr, res_valid, res_data, res_err, busy
  );

endinterface

// File: rtl/dlfloat_mac_seq.sv
// Dot-product job sequencer: clears the external MAC, streams operand pairs
// into it, waits out the MAC pipeline and holds the accumulated result.
module dlfloat_mac_seq
  import dlfloat_pkg::*;
#(
  parameter int MAC_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dlfloat_mac_seq_if.slave  bus
);

  // The drain counter must hold MAC_LAT and be at least one bit wide.
  localparam int DRN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [DLF_W-1:0] mac_a_q, mac_a_d;
  logic [DLF_W-1:0] mac_b_q, mac_b_d;
  logic [DLF_W-1:0] res_data_q, res_data_d;
  logic             err_q, err_d;

  // Next-state, counter and datapath-register decisions for the job FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    rem_d      = rem_q;
    drn_d      = drn_q;
    mac_a_d    = DLF_ZERO;  // zero operands leave the accumulator unchanged
    mac_b_d    = DLF_ZERO;
    res_data_d = res_data_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          rem_d = bus.vec_len;
          err_d = 1'b0;
          if (bus.vec_len == '0) begin
            res_data_d = DLF_ZERO;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED: begin
        if (bus.op_valid) begin
          mac_a_d = bus.op_a;
          mac_b_d = bus.op_b;
          if (is_nan(bus.op_a) || is_nan(bus.op_b)) err_d = 1'b1;
          // Last pair: hold remaining at 1 rather than letting it reach 0 or wrap.
          if (rem_q <= CNT_W'(1)) begin
            drn_d   = DRN_W'(MAC_LAT);
            state_d = ST_DRAIN;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drn_q == '0) begin
          res_data_d = bus.mac_c;
          state_d    = ST_DONE;
        end else begin
          drn_d = drn_q - DRN_W'(1);
        end
      end
      ST_DONE: if (bus.res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      drn_q      <= '0;
      mac_a_q    <= DLF_ZERO;
      mac_b_q    <= DLF_ZERO;
      res_data_q <= DLF_ZERO;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rem_q      <= rem_d;
      drn_q      <= drn_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      res_data_q <= res_data_d;
      err_q      <= err_d;
    end
  end

  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.mac_clr   = (state_q == ST_CLEAR);
  assign bus.op_ready  = (state_q == ST_FEED);
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = err_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// Self-checking bench for dlfloat_mac_seq with a behavioural DLFloat MAC.
module tb_dlfloat_mac_seq;
  import dlfloat_pkg::*;

  localparam int MAC_LAT = 2;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dlfloat_mac_seq_if #(.CNT_W(CNT_W)) bus();

  dlfloat_mac_seq #(.MAC_LAT(MAC_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int clr_cnt = 0;
  int rdy_cnt = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] exp_res;

  // DLFloat value as a real; exponent 0 is treated as zero.
  function automatic real dec(input logic [15:0] x);
    real v;
    int  e;
    e = int'(x[14:9]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(x[8:0]) / 512.0;
    e = e - DLF_BIAS;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[15] ? -v : v;
  endfunction

  // Real to DLFloat with truncation, saturating below the NaN pattern.
  function automatic logic [15:0] enc(input real v);
    logic s;
    int   e;
    int   m;
    s = (v < 0.0);
    if (s) v = -v;
    if (v == 0.0) return 16'h0000;
    e = DLF_BIAS;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    if (e > 62) return {s, 6'd62, 9'h1FF};
    if (e < 1) return 16'h0000;
    m = $rtoi((v - 1.0) * 512.0);
    return {s, 6'(e), 9'(m)};
  endfunction

  function automatic logic [15:0] rnd_op();
    if ($urandom_range(0, 9) == 0) return DLF_NAN;
    return {1'($urandom), 6'($urandom_range(28, 34)), 9'($urandom)};
  endfunction

  // Behavioural MAC: accumulate in reals, result visible MAC_LAT cycles after operands.
  real         acc;
  logic        acc_nan;
  logic [15:0] mac_c_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= 0.0;
      acc_nan <= 1'b0;
      mac_c_q <= 16'h0000;
    end else begin
      mac_c_q <= acc_nan ? DLF_NAN : enc(acc);
      if (bus.mac_clr) begin
        acc     <= 0.0;
        acc_nan <= 1'b0;
      end else begin
        acc     <= acc + dec(bus.mac_a) * dec(bus.mac_b);
        acc_nan <= acc_nan | is_nan(bus.mac_a) | is_nan(bus.mac_b);
      end
    end
  end
  assign bus.mac_c = mac_c_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mac_clr)  clr_cnt <= clr_cnt + 1;
    if (bus.op_ready) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mac_a"},     32'(bus.mac_a),     32'h0);
    check({tag, "_mac_b"},     32'(bus.mac_b),     32'h0);
    check({tag, "_mac_clr"},   32'(bus.mac_clr),   32'h0);
    check({tag, "_op_ready"},  32'(bus.op_ready),  32'h0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 32'h0);
    check({tag, "_res_data"},  32'(bus.res_data),  32'h0);
    check({tag, "_res_err"},   32'(bus.res_err),   32'h0);
    check({tag, "_busy"},      32'(bus.busy),      32'h0);
  endtask

  // Runs one job from IDLE with operands qa/qb, random bubbles in [bmin,bmax],
  // and returns at the first negedge with res_valid high (or on timeout).
  task automatic run_job(input int len, input int bmin, input int bmax);
    real         sum;
    logic        nan;
    logic [15:0] exp_ma, exp_mb;
    int          idx, bub, guard, h_cyc, clr0, rdy0;
    logic        hs;
    sum = 0.0;
    nan = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (qa[i] == DLF_NAN || qb[i] == DLF_NAN) nan = 1'b1;
      sum = sum + dec(qa[i]) * dec(qb[i]);
    end
    exp_res = (len == 0) ? 16'h0000 : (nan ? DLF_NAN : enc(sum));
    clr0 = clr_cnt;
    rdy0 = rdy_cnt;
    bus.start   = 1'b1;
    bus.vec_len = CNT_W'(len);
    @(negedge clk);
    bus.start = 1'b0;
    check("job_busy", 32'(bus.busy), 32'h1);
    check("job_err_clr", 32'(bus.res_err), 32'h0);
    idx = 0; guard = 0; h_cyc = cyc;
    exp_ma = 16'h0000; exp_mb = 16'h0000;
    bub = $urandom_range(bmin, bmax);
    while (!bus.res_valid && guard < 2000) begin
      check("feed_mac_a", 32'(bus.mac_a), 32'(exp_ma));
      check("feed_mac_b", 32'(bus.mac_b), 32'(exp_mb));
      exp_ma = 16'h0000; exp_mb = 16'h0000; hs = 1'b0;
      bus.op_valid = 1'b0;
      bus.op_a = 16'($urandom);
      bus.op_b = 16'($urandom);
      if (bus.op_ready && idx < len) begin
        if (bub > 0) begin
          bub--;
        end else begin
          bus.op_valid = 1'b1;
          bus.op_a = qa[idx];
          bus.op_b = qb[idx];
          exp_ma = qa[idx];
          exp_mb = qb[idx];
          idx++;
          hs = 1'b1;
          bub = $urandom_range(bmin, bmax);
        end
      end
      @(negedge clk);
      guard++;
      if (hs) begin
        h_cyc = cyc;
        if (idx == len) check("rdy_drop", 32'(bus.op_ready), 32'h0);
      end
    end
    bus.op_valid = 1'b0;
    check("res_valid", 32'(bus.res_valid), 32'h1);
    check("res_data", 32'(bus.res_data), 32'(exp_res));
    check("res_err", 32'(bus.res_err), 32'(nan));
    if (len > 0) begin
      check("latency", 32'(cyc - h_cyc), 32'(MAC_LAT + 1));
      check("clr_pulses", 32'(clr_cnt - clr0), 32'h1);
      check("pairs_taken", 32'(idx), 32'(len));
    end else begin
      check("zero_clr", 32'(clr_cnt - clr0), 32'h0);
      check("zero_rdy", 32'(rdy_cnt - rdy0), 32'h0);
    end
  endtask

  // Holds DONE for 'hold' cycles while pulsing start, then completes the handshake
  // with a simultaneous start that must be ignored.
  task automatic finish_job(input int hold);
    for (int i = 0; i < hold; i++) begin
      bus.res_ready = 1'b0;
      bus.start     = i[0];
      bus.vec_len   = CNT_W'(5);
      @(negedge clk);
      check("hold_valid", 32'(bus.res_valid), 32'h1);
      check("hold_data", 32'(bus.res_data), 32'(exp_res));
    end
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
    check("rel_valid", 32'(bus.res_valid), 32'h0);
    check("rel_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    check("rel_idle", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int g;
    int len;
    bus.start = 1'b0; bus.vec_len = '0; bus.op_valid = 1'b0;
    bus.op_a = 16'h0; bus.op_b = 16'h0; bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Three back-to-back pairs of 1.0 x 2.0 -> 6.0.
    qa = '{16'h3E00, 16'h3E00, 16'h3E00};
    qb = '{16'h4000, 16'h4000, 16'h4000};
    run_job(3, 0, 0);
    check("dot_6p0", 32'(bus.res_data), 32'h4300);
    finish_job(0);

    // Same job with two-cycle bubbles between pairs.
    run_job(3, 2, 2);
    check("dot_6p0_bub", 32'(bus.res_data), 32'h4300);
    finish_job(1);

    // Empty job.
    run_job(0, 0, 0);
    finish_job(0);

    // NaN in the second pair; result held under a stalled consumer.
    qa = '{16'h3E00, 16'hFFFF, 16'h3E00};
    qb = '{16'h4000, 16'h4000, 16'h4000};
    run_job(3, 0, 1);
    check("nan_data", 32'(bus.res_data), 32'hFFFF);
    check("nan_err", 32'(bus.res_err), 32'h1);
    finish_job(5);

    // Next start clears res_err.
    qa = '{16'h4000, 16'h3E00};
    qb = '{16'h3E00, 16'h3E00};
    run_job(2, 0, 1);
    finish_job(2);

    // Reset in FEED after one of four pairs.
    bus.start = 1'b1; bus.vec_len = CNT_W'(4);
    @(negedge clk);
    bus.start = 1'b0;
    g = 0;
    while (!bus.op_ready && g < 10) begin @(negedge clk); g++; end
    check("mid_ready", 32'(bus.op_ready), 32'h1);
    bus.op_valid = 1'b1; bus.op_a = 16'h3E00; bus.op_b = 16'h4000;
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("mid_mac_a", 32'(bus.mac_a), 32'h3E00);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    qa = '{16'h3E00};
    qb = '{16'h3E00};
    run_job(1, 0, 0);
    check("post_rst", 32'(bus.res_data), 32'h3E00);
    finish_job(0);

    // Randomised jobs.
    for (int j = 0; j < 8; j++) begin
      len = $urandom_range(1, 6);
      qa.delete(); qb.delete();
      for (int i = 0; i < len; i++) begin
        qa.push_back(rnd_op());
        qb.push_back(rnd_op());
      end
      run_job(len, 0, 2);
      finish_job($urandom_range(0, 3));
    end

    // Longest job the length field allows.
    len = (1 << CNT_W) - 1;
    qa.delete(); qb.delete();
    for (int i = 0; i < len; i++) begin
      qa.push_back({1'($urandom), 6'($urandom_range(28, 33)), 9'($urandom)});
      qb.push_back({1'($urandom), 6'($urandom_range(28, 33)), 9'($urandom)});
    end
    run_job(len, 0, 0);
    finish_job(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dlfloat_mac_seq.md
DLFLOAT_MAC_SEQ -- requirements
Module: dlfloat_mac_seq

Interface
REQ-001 SHALL have parameter MAC_LAT, default 2: cycles from operand presentation on mac_a/mac_b to the updated accumulator on mac_c.
REQ-002 SHALL have parameter CNT_W, default 8: width of the vector-length field.
REQ-003 SHALL have one clock; reset is asynchronous and active-low, with ports named clk and rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin a dot-product job.
REQ-007 vec_len  in  CNT_W  number of operand pairs in the job, sampled with start.
REQ-008 op_valid  in  1  operand pair available.
REQ-009 op_ready  out  1  sequencer accepts the operand pair.
REQ-010 op_a, op_b  in  16  DLFloat operands (sign, 6-bit exponent with bias 31, 9-bit mantissa).
REQ-011 mac_a, mac_b  out  16  registered operands to the MAC datapath.
REQ-012 mac_clr  out  1  synchronous accumulator clear strobe.
REQ-013 mac_c  in  16  MAC accumulator value.
REQ-014 res_valid  out  1  result available.
REQ-015 res_ready  in  1  consumer takes the result.
REQ-016 res_data  out  16  captured dot-product result.
REQ-017 res_err  out  1  NaN operand (16'hFFFF) was seen in the job.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 SHALL implement a five-state FSM: IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-020 IDLE: with start=1, latch vec_len into remaining and clear res_err; go to DONE with res_data=0 if vec_len==0, otherwise go to CLEAR.
REQ-021 CLEAR: assert mac_clr for exactly one cycle with mac_a=mac_b=0, then go to FEED.
REQ-022 FEED: op_ready=1; on op_valid&&op_ready, register op_a/op_b onto mac_a/mac_b at that edge and decrement remaining.
REQ-023 FEED: in any cycle without a handshake, drive mac_a=mac_b=16'h0000 so the accumulator is unchanged; bubbles are legal at any point.
REQ-024 On acceptance of the last pair (remaining==1), go to DRAIN and load the drain counter with MAC_LAT; op_ready deasserts from the next cycle.
REQ-025 DRAIN: mac_a/mac_b held at 0; when the drain counter expires, capture mac_c into res_data and go to DONE.
REQ-026 Total latency, last handshake to res_valid rising: MAC_LAT+1 cycles.
REQ-027 DONE: hold res_valid=1 and res_data stable until res_ready=1; on the handshake, go to IDLE with res_valid=0 the next cycle.
REQ-028 start SHALL be ignored whenever busy=1; start arriving in the same cycle as the DONE handshake is ignored.
REQ-029 res_err SHALL set when any accepted op_a or op_b equals 16'hFFFF; it stays set until the next accepted start.
REQ-030 res_data SHALL pass through the datapath value unmodified, including 16'hFFFF.
REQ-031 remaining SHALL never decrement below 1 in FEED, with no wrap.
REQ-032 vec_len=2^CNT_W-1 SHALL be supported.

Reset
REQ-033 While rst_n=0, the FSM SHALL be in IDLE; remaining and the drain counter SHALL be 0.
REQ-034 Outputs while rst_n=0: mac_a=mac_b=0, mac_clr=0, op_ready=0, res_valid=0, res_data=0, res_err=0, busy=0.
REQ-035 Reset asserted mid-job SHALL abort the job immediately; no partial result is emitted, and the first job after release starts with CLEAR.

Structure
REQ-036 Shared package dlfloat_pkg SHALL hold DLF_W=16, DLF_NAN=16'hFFFF, DLF_ZERO=16'h0000, DLF_BIAS=31 and the FSM state encoding type.
REQ-037 No sub-module is required: one FSM plus two counters in a single module, instantiated alongside the existing MAC.

Verification
REQ-038 Reset, then start with vec_len=3 and three back-to-back pairs (16'h3E00, 16'h4000) -> one mac_clr pulse, res_data=16'h4300 (6.0) exactly 3 cycles after the last handshake, res_err=0.
REQ-039 Same job with op_valid low for 2 cycles between pairs -> mac_a/mac_b=0 during the bubbles, result unchanged at 16'h4300.
REQ-040 start with vec_len=0 -> DONE next cycle, res_data=0, no mac_clr pulse, op_ready never high.
REQ-041 Second pair has op_a=16'hFFFF -> res_err=1 and res_data=16'hFFFF; res_err clears on the next start.
REQ-042 Hold res_ready=0 for 5 cycles in DONE while pulsing start -> res_valid and res_data stable, start ignored, IDLE one cycle after res_ready=1.
REQ-043 Pulse rst_n low during FEED after 1 of 4 pairs -> all outputs zero immediately; a new job with vec_len=1 of (16'h3E00, 16'h3E00) gives 16'h3E00.
